// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: command codes and FSM state encoding.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StOpA,
        StOpB,
        StFun,
        StAluWait,
        StTxLo,
        StTxHi
    } cmd_state_t;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Parses command frames from the UART RX byte stream, drives register-file and ALU strobes,
// and returns read/ALU results to the TX FIFO through a valid/full handshake.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned ALU_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_DATA_VALID,
    input  logic              RX_ERR,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_DATA_VALID,
    input  logic              TX_FULL,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic              RF_WR_EN,
    output logic [DATA_W-1:0] RF_WR_DATA,
    output logic              RF_RD_EN,
    input  logic [DATA_W-1:0] RF_RD_DATA,
    input  logic              RF_RD_VALID,
    output logic              ALU_EN,
    output logic [3:0]        ALU_FUN,
    input  logic [ALU_W-1:0]  ALU_OUT,
    input  logic              ALU_OUT_VALID
);

    cmd_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        fun_q, fun_d;
    logic [ALU_W-1:0]  res_q, res_d;
    logic              two_q, two_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              alu_en_q, alu_en_d;

    logic rx_ok;
    logic rx_bad;
    logic tx_valid;
    logic tx_acc;
    logic parsing;

    assign rx_ok    = RX_DATA_VALID && !RX_ERR;
    assign rx_bad   = RX_DATA_VALID && RX_ERR;
    assign tx_valid = (state_q == StTxLo) || (state_q == StTxHi);
    assign tx_acc   = tx_valid && !TX_FULL;
    assign parsing  = (state_q == StIdle) || (state_q == StWrAddr) || (state_q == StWrData) ||
                      (state_q == StRdAddr) || (state_q == StOpA) || (state_q == StOpB) ||
                      (state_q == StFun);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fun_d    = fun_q;
        res_d    = res_q;
        two_d    = two_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        alu_en_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_ok) begin
                    case (RX_P_DATA)
                        CMD_RF_WR:   state_d = StWrAddr;
                        CMD_RF_RD:   state_d = StRdAddr;
                        CMD_ALU_OP:  state_d = StOpA;
                        CMD_ALU_NOP: state_d = StFun;
                        default:     state_d = StIdle;
                    endcase
                end
            end
            StWrAddr: if (rx_ok) begin
                addr_d  = RX_P_DATA[ADDR_W-1:0];
                state_d = StWrData;
            end
            StWrData: if (rx_ok) begin
                wdata_d = RX_P_DATA;
                wr_en_d = 1'b1;
                state_d = StIdle;
            end
            StRdAddr: if (rx_ok) begin
                addr_d  = RX_P_DATA[ADDR_W-1:0];
                rd_en_d = 1'b1;
                two_d   = 1'b0;
                state_d = StRdWait;
            end
            StRdWait: if (RF_RD_VALID) begin
                res_d   = ALU_W'(RF_RD_DATA);
                state_d = StTxLo;
            end
            StOpA: if (rx_ok) begin
                addr_d  = '0;
                wdata_d = RX_P_DATA;
                wr_en_d = 1'b1;
                state_d = StOpB;
            end
            StOpB: if (rx_ok) begin
                addr_d  = ADDR_W'(1);
                wdata_d = RX_P_DATA;
                wr_en_d = 1'b1;
                state_d = StFun;
            end
            StFun: if (rx_ok) begin
                fun_d    = RX_P_DATA[3:0];
                alu_en_d = 1'b1;
                two_d    = 1'b1;
                state_d  = StAluWait;
            end
            StAluWait: if (ALU_OUT_VALID) begin
                res_d   = ALU_OUT;
                state_d = StTxLo;
            end
            StTxLo: if (tx_acc) state_d = two_q ? StTxHi : StIdle;
            StTxHi: if (tx_acc) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // An errored byte anywhere in a frame drops the whole frame.
        if (rx_bad && parsing) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            fun_q    <= '0;
            res_q    <= '0;
            two_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            alu_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fun_q    <= fun_d;
            res_q    <= res_d;
            two_q    <= two_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            alu_en_q <= alu_en_d;
        end
    end

    always_comb begin
        TX_P_DATA = '0;
        if (state_q == StTxLo) begin
            TX_P_DATA = res_q[DATA_W-1:0];
        end else if (state_q == StTxHi) begin
            TX_P_DATA = res_q[2*DATA_W-1:DATA_W];
        end
    end

    assign TX_DATA_VALID = tx_valid;
    assign RF_ADDR       = addr_q;
    assign RF_WR_EN      = wr_en_q;
    assign RF_WR_DATA    = wdata_q;
    assign RF_RD_EN      = rd_en_q;
    assign ALU_EN        = alu_en_q;
    assign ALU_FUN       = fun_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboarded bench for uart_cmd_ctrl with simple register-file and ALU response models.
module tb_uart_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_DATA_VALID = 1'b0;
    logic        RX_ERR = 1'b0;
    logic [7:0]  TX_P_DATA;
    logic        TX_DATA_VALID;
    logic        TX_FULL = 1'b0;
    logic [3:0]  RF_ADDR;
    logic        RF_WR_EN;
    logic [7:0]  RF_WR_DATA;
    logic        RF_RD_EN;
    logic [7:0]  RF_RD_DATA = 8'h00;
    logic        RF_RD_VALID = 1'b0;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        ALU_OUT_VALID = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [11:0] wr_q[$];
    logic [7:0]  tx_q[$];
    logic [3:0]  fun_q[$];

    logic [7:0]  rf_mem[16];
    logic        rf_stall = 1'b0;
    logic [15:0] alu_res = 16'h0000;
    int          alu_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    uart_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_DATA_VALID (RX_DATA_VALID),
        .RX_ERR        (RX_ERR),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .TX_FULL       (TX_FULL),
        .RF_ADDR       (RF_ADDR),
        .RF_WR_EN      (RF_WR_EN),
        .RF_WR_DATA    (RF_WR_DATA),
        .RF_RD_EN      (RF_RD_EN),
        .RF_RD_DATA    (RF_RD_DATA),
        .RF_RD_VALID   (RF_RD_VALID),
        .ALU_EN        (ALU_EN),
        .ALU_FUN       (ALU_FUN),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VALID (ALU_OUT_VALID)
    );

    always #5 CLK = ~CLK;

    // RF answers one cycle after the read strobe; ALU answers three cycles after start.
    always @(posedge CLK) begin
        RF_RD_VALID   <= 1'b0;
        ALU_OUT_VALID <= 1'b0;
        if (RF_WR_EN) rf_mem[RF_ADDR] <= RF_WR_DATA;
        if (RF_RD_EN && !rf_stall) begin
            RF_RD_VALID <= 1'b1;
            RF_RD_DATA  <= rf_mem[RF_ADDR];
        end
        if (ALU_EN) begin
            alu_cnt <= 3;
        end else if (alu_cnt > 0) begin
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1) begin
                ALU_OUT_VALID <= 1'b1;
                ALU_OUT       <= alu_res;
            end
        end
    end

    always @(negedge CLK) begin
        logic [11:0] ew;
        logic [7:0]  et;
        logic [3:0]  ef;
        if (RST) begin
            prev_hold = 1'b0;
        end else begin
            if (RF_WR_EN) begin
                total++;
                if (wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL rf_write: got addr=%0h data=%0h, required no write",
                             RF_ADDR, RF_WR_DATA);
                end else begin
                    ew = wr_q.pop_front();
                    if ({RF_ADDR, RF_WR_DATA} !== ew) begin
                        bad++;
                        $display("FAIL rf_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                                 RF_ADDR, RF_WR_DATA, ew[11:8], ew[7:0]);
                    end
                end
            end
            if (ALU_EN) begin
                total++;
                if (fun_q.size() == 0) begin
                    bad++;
                    $display("FAIL alu_start: got fun=%0h, required no start", ALU_FUN);
                end else begin
                    ef = fun_q.pop_front();
                    if (ALU_FUN !== ef) begin
                        bad++;
                        $display("FAIL alu_start: got fun=%0h, required fun=%0h", ALU_FUN, ef);
                    end
                end
            end
            if (prev_hold) begin
                total++;
                if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== prev_data) begin
                    bad++;
                    $display("FAIL tx_hold: got valid=%0b data=%0h, required valid=1 data=%0h",
                             TX_DATA_VALID, TX_P_DATA, prev_data);
                end
            end
            if (TX_DATA_VALID && !TX_FULL) begin
                total++;
                if (tx_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_byte: got %0h, required no byte", TX_P_DATA);
                end else begin
                    et = tx_q.pop_front();
                    if (TX_P_DATA !== et) begin
                        bad++;
                        $display("FAIL tx_byte: got %0h, required %0h", TX_P_DATA, et);
                    end
                end
            end
            prev_hold = TX_DATA_VALID && TX_FULL;
            prev_data = TX_P_DATA;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        RX_P_DATA     = b;
        RX_DATA_VALID = 1'b1;
        RX_ERR        = e;
        tick();
        RX_DATA_VALID = 1'b0;
        RX_ERR        = 1'b0;
        RX_P_DATA     = 8'h00;
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(negedge CLK);
        #1;
        while ((tx_q.size() != 0 || wr_q.size() != 0 || fun_q.size() != 0) && n < 200) begin
            @(negedge CLK);
            #1;
            n++;
        end
        total++;
        if (tx_q.size() != 0 || wr_q.size() != 0 || fun_q.size() != 0) begin
            bad++;
            $display("FAIL %s drain: got pending tx=%0d wr=%0d alu=%0d, required all 0",
                     name, tx_q.size(), wr_q.size(), fun_q.size());
            tx_q.delete();
            wr_q.delete();
            fun_q.delete();
        end
        @(negedge CLK);
        #1;
        total++;
        if (TX_DATA_VALID !== 1'b0) begin
            bad++;
            $display("FAIL %s tx_idle: got valid=%0b, required 0", name, TX_DATA_VALID);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        total++;
        if ({TX_DATA_VALID, TX_P_DATA, RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN}
            !== 31'd0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%0b tx=%0h addr=%0h fun=%0h, required all 0",
                     TX_DATA_VALID, TX_P_DATA, RF_ADDR, ALU_FUN);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_write();
        wr_q.push_back({4'h5, 8'h3C});
        send(8'hAA, 1'b0);
        send(8'h05, 1'b0);
        send(8'h3C, 1'b0);
        drain("write");
    endtask

    task automatic test_read();
        tx_q.push_back(8'h3C);
        send(8'hBB, 1'b0);
        send(8'h05, 1'b0);
        total++;
        if (RF_RD_EN !== 1'b1 || RF_ADDR !== 4'h5) begin
            bad++;
            $display("FAIL read_strobe: got rd_en=%0b addr=%0h, required rd_en=1 addr=5",
                     RF_RD_EN, RF_ADDR);
        end
        drain("read");
    endtask

    task automatic test_alu_op();
        alu_res = 16'h0030;
        wr_q.push_back({4'h0, 8'h10});
        wr_q.push_back({4'h1, 8'h20});
        fun_q.push_back(4'h0);
        tx_q.push_back(8'h30);
        tx_q.push_back(8'h00);
        send(8'hCC, 1'b0);
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h00, 1'b0);
        drain("alu_op");
    endtask

    task automatic test_alu_backpressure();
        int n = 0;
        alu_res = 16'h1234;
        TX_FULL = 1'b1;
        fun_q.push_back(4'h2);
        send(8'hDD, 1'b0);
        send(8'h02, 1'b0);
        while (TX_DATA_VALID !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'h34) begin
            bad++;
            $display("FAIL bp_first: got valid=%0b data=%0h, required valid=1 data=34",
                     TX_DATA_VALID, TX_P_DATA);
        end
        repeat (5) tick();
        tx_q.push_back(8'h34);
        tx_q.push_back(8'h12);
        TX_FULL = 1'b0;
        drain("alu_backpressure");
    endtask

    task automatic test_abort();
        wr_q.push_back({4'h6, 8'h77});
        send(8'hAA, 1'b0);
        send(8'h05, 1'b0);
        send(8'h3C, 1'b1);
        send(8'hAA, 1'b0);
        send(8'h06, 1'b0);
        send(8'h77, 1'b0);
        drain("abort");
    endtask

    task automatic test_back_to_back();
        wr_q.push_back({4'h3, 8'h11});
        tx_q.push_back(8'h11);
        send(8'hAA, 1'b0);
        send(8'h03, 1'b0);
        send(8'h11, 1'b0);
        send(8'hBB, 1'b0);
        send(8'h03, 1'b0);
        drain("back_to_back");
    endtask

    task automatic test_unknown_and_reset();
        rf_stall = 1'b1;
        send(8'h55, 1'b0);
        send(8'hBB, 1'b0);
        send(8'h02, 1'b0);
        total++;
        if (RF_RD_EN !== 1'b1 || RF_ADDR !== 4'h2) begin
            bad++;
            $display("FAIL unknown_ignored: got rd_en=%0b addr=%0h, required rd_en=1 addr=2",
                     RF_RD_EN, RF_ADDR);
        end
        tick();
        tick();
        RST = 1'b1;
        tick();
        total++;
        if ({TX_DATA_VALID, TX_P_DATA, RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN}
            !== 31'd0) begin
            bad++;
            $display("FAIL midframe_reset: got valid=%0b tx=%0h addr=%0h fun=%0h, required all 0",
                     TX_DATA_VALID, TX_P_DATA, RF_ADDR, ALU_FUN);
        end
        RST = 1'b0;
        rf_stall = 1'b0;
        tick();
        tx_q.push_back(8'h20);
        send(8'hBB, 1'b0);
        send(8'h01, 1'b0);
        drain("after_reset_read");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_alu_op();
        test_alu_backpressure();
        test_abort();
        test_back_to_back();
        test_unknown_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
